// File: rtl/sha256_stream_padder_if.sv
// Byte-stream and core-side signal bundle for the SHA-256 padder.
// slave: the padder's view; master: the host/core view driving it.
interface sha256_stream_padder_if #(
    parameter int IN_BYTES = 1
);
    localparam int NB_W = $clog2(IN_BYTES) + 1;

    logic                  start;
    logic [8*IN_BYTES-1:0] data_in;
    logic                  data_valid;
    logic                  data_last;
    logic [NB_W-1:0]       data_bytes;
    logic                  in_ready;
    logic [511:0]          core_block;
    logic                  core_start;
    logic                  core_first;
    logic                  core_ready;
    logic                  done;
    logic                  busy;

    modport slave (
        input  start, data_in, data_valid, data_last, data_bytes,
        input  core_ready,
        output in_ready, core_block, core_start, core_first,
        output done, busy
    );

    modport master (
        output start, data_in, data_valid, data_last, data_bytes,
        output core_ready,
        input  in_ready, core_block, core_start, core_first,
        input  done, busy
    );
endinterface

// File: rtl/sha256_stream_padder.sv
// SHA-256 front-end: packs IN_BYTES beats into 512-bit blocks, pads, issues.
// Ports: clk, rst (async high), bus (stream in, core block/start out).
module sha256_stream_padder #(
    parameter int IN_BYTES = 1,
    parameter int LEN_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    sha256_stream_padder_if.slave        bus
);
    localparam int NB_W = $clog2(IN_BYTES) + 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, PAD, ISSUE, WAIT, XPAD, DONE
    } state_t;

    state_t           state;
    logic [7:0]       blk [64];
    logic [6:0]       byte_idx;
    logic [6:0]       p;
    logic [LEN_W-1:0] cnt;
    logic             first;
    logic             fin;
    logic             xpad;
    logic             mark_done;
    logic             rdy_prev;
    logic             start_q;
    logic             first_q;

    logic             idle_like;
    logic             acc;
    logic [6:0]       base;
    logic [LEN_W-1:0] cnt_base;
    logic [63:0]      bitlen;
    logic [511:0]     flat;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign bus.in_ready = (state == LOAD) || (idle_like && bus.start);
    assign acc = bus.data_valid && bus.in_ready;

    // A beat taken together with start lands at byte 0 of a fresh message.
    assign base     = idle_like ? 7'd0 : byte_idx;
    assign cnt_base = idle_like ? '0 : cnt;
    assign bitlen   = 64'({cnt, 3'b000});

    always_comb begin
        flat = '0;
        for (int j = 0; j < 64; j++) begin
            flat[511-8*j -: 8] = blk[j];
        end
    end

    assign bus.core_block = flat;
    assign bus.core_start = start_q;
    assign bus.core_first = first_q;
    assign bus.done       = (state == DONE);
    assign bus.busy       = !idle_like;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            byte_idx  <= '0;
            p         <= '0;
            cnt       <= '0;
            first     <= 1'b0;
            fin       <= 1'b0;
            xpad      <= 1'b0;
            mark_done <= 1'b0;
            rdy_prev  <= 1'b0;
            start_q   <= 1'b0;
            first_q   <= 1'b0;
            for (int j = 0; j < 64; j++) begin
                blk[j] <= 8'h00;
            end
        end else begin
            rdy_prev <= bus.core_ready;
            start_q  <= 1'b0;
            first_q  <= 1'b0;

            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        byte_idx  <= '0;
                        cnt       <= '0;
                        first     <= 1'b1;
                        fin       <= 1'b0;
                        xpad      <= 1'b0;
                        mark_done <= 1'b0;
                        state     <= LOAD;
                        for (int j = 0; j < 64; j++) begin
                            blk[j] <= 8'h00;
                        end
                    end
                end
                LOAD: begin
                end
                PAD: begin
                    for (int j = 0; j < 64; j++) begin
                        if (p < 7'd64) begin
                            if (7'(j) == p) begin
                                blk[j] <= 8'h80;
                            end else if (7'(j) > p) begin
                                blk[j] <= 8'h00;
                            end
                        end
                    end
                    if (p <= 7'd55) begin
                        for (int k = 0; k < 8; k++) begin
                            blk[56+k] <= bitlen[63-8*k -: 8];
                        end
                    end
                    fin       <= (p <= 7'd55);
                    xpad      <= (p > 7'd55);
                    mark_done <= (p < 7'd64);
                    state     <= ISSUE;
                end
                ISSUE: begin
                    if (bus.core_ready) begin
                        start_q <= 1'b1;
                        first_q <= first;
                        first   <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.core_ready && !rdy_prev) begin
                        if (fin) begin
                            state <= DONE;
                        end else if (xpad) begin
                            state <= XPAD;
                        end else begin
                            byte_idx <= '0;
                            state    <= LOAD;
                            for (int j = 0; j < 64; j++) begin
                                blk[j] <= 8'h00;
                            end
                        end
                    end
                end
                XPAD: begin
                    for (int j = 0; j < 56; j++) begin
                        blk[j] <= 8'h00;
                    end
                    blk[0] <= mark_done ? 8'h00 : 8'h80;
                    for (int k = 0; k < 8; k++) begin
                        blk[56+k] <= bitlen[63-8*k -: 8];
                    end
                    fin   <= 1'b1;
                    xpad  <= 1'b0;
                    state <= ISSUE;
                end
                default: state <= IDLE;
            endcase

            // Beat capture overrides the state-case defaults above.
            if (acc) begin
                for (int i = 0; i < IN_BYTES; i++) begin
                    if (!bus.data_last || (NB_W'(i) < bus.data_bytes)) begin
                        blk[base[5:0] + 6'(i)] <=
                            bus.data_in[8*(IN_BYTES-i)-1 -: 8];
                    end else begin
                        blk[base[5:0] + 6'(i)] <= 8'h00;
                    end
                end
                if (bus.data_last) begin
                    cnt   <= cnt_base + LEN_W'(bus.data_bytes);
                    p     <= base + 7'(bus.data_bytes);
                    state <= PAD;
                end else begin
                    cnt      <= cnt_base + LEN_W'(IN_BYTES);
                    byte_idx <= base + 7'(IN_BYTES);
                    state    <= (base + 7'(IN_BYTES) == 7'd64) ? ISSUE : LOAD;
                end
            end
        end
    end
endmodule

// File: tb/tb_sha256_stream_padder.sv
// Randomised bench for sha256_stream_padder with a reference padding model.
// A model core captures issued blocks; results compared per message.
module tb_sha256_stream_padder;
    localparam int IB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sha256_stream_padder_if #(.IN_BYTES(IB)) bus ();

    sha256_stream_padder #(
        .IN_BYTES(IB),
        .LEN_W   (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [511:0] got,
                       input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // ---------------- model core ----------------
    int           cyc = 0;
    int           rise_cyc = 0;
    int           bp_cnt = 0;
    int           stab_cnt = 0;
    int           busy_cnt = 0;
    logic [511:0] last_blk;
    logic [511:0] cap_blk[$];
    logic         cap_first[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.core_ready <= 1'b1;
            busy_cnt       <= 0;
        end else if (bus.core_start) begin
            cap_blk.push_back(bus.core_block);
            cap_first.push_back(bus.core_first);
            last_blk       <= bus.core_block;
            bus.core_ready <= 1'b0;
            busy_cnt       <= int'($urandom_range(1, 4));
        end else if (!bus.core_ready) begin
            if (bus.core_block !== last_blk) stab_cnt <= stab_cnt + 1;
            if (busy_cnt <= 1) begin
                bus.core_ready <= 1'b1;
                rise_cyc       <= cyc + 1;
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    // The padder must never take beats while the core is crunching.
    always @(negedge clk) begin
        if (!bus.core_ready && bus.in_ready) bp_cnt <= bp_cnt + 1;
    end

    // ---------------- reference model ----------------
    logic [7:0]   msg[$];
    logic [511:0] exp_b[$];

    task automatic fill(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    task automatic build_exp();
        logic [7:0]   q[$];
        logic [63:0]  bits;
        logic [511:0] b;
        q = msg;
        q.push_back(8'h80);
        while (q.size() % 64 != 56) q.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) q.push_back(bits[8*k +: 8]);
        exp_b.delete();
        for (int i = 0; i < q.size(); i += 64) begin
            b = '0;
            for (int j = 0; j < 64; j++) b = {b[503:0], q[i+j]};
            exp_b.push_back(b);
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_msg(input bit swb, input bit empty_tail);
        int          nb, nfull, rem, bi, n0, bp0, st0, nbytes;
        bit          st, acc, last, seen_busy, got_done;
        logic [31:0] d;
        string       tg;
        build_exp();
        n0  = cap_blk.size();
        bp0 = bp_cnt;
        st0 = stab_cnt;
        nfull = msg.size() / 4;
        rem   = msg.size() % 4;
        nb = (rem == 0 && nfull > 0 && !empty_tail) ? nfull : nfull + 1;
        bi = 0;
        st = 1'b1;
        seen_busy = 1'b0;
        for (int c = 0; c < 4000 && bi < nb; c++) begin
            @(negedge clk);
            if (bus.busy) seen_busy = 1'b1;
            last   = (bi == nb - 1);
            nbytes = last ? msg.size() - 4*bi : 4;
            for (int k = 0; k < 4; k++) begin
                if (k < nbytes) d[31-8*k -: 8] = msg[4*bi+k];
                else            d[31-8*k -: 8] = 8'($urandom);
            end
            bus.data_in    = d;
            bus.data_last  = last;
            bus.data_bytes = nbytes[2:0];
            bus.start      = st;
            bus.data_valid = st ? swb : ($urandom_range(0, 3) != 0);
            #1 acc = bus.data_valid && bus.in_ready;
            @(posedge clk);
            st = 1'b0;
            if (acc) bi++;
        end
        @(negedge clk);
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
        tg = $sformatf("L%0d", msg.size());
        chk({tg, " beats"}, bi, nb);
        got_done = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy) seen_busy = 1'b1;
            @(negedge clk);
        end
        chk({tg, " done"}, got_done, 1);
        chk({tg, " done_lat"}, cyc - rise_cyc, 1);
        chk({tg, " busy_seen"}, seen_busy, 1);
        chk({tg, " busy_done"}, bus.busy, 0);
        chk({tg, " nblk"}, cap_blk.size() - n0, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            if (n0 + i < cap_blk.size()) begin
                chk($sformatf("%s blk%0d", tg, i), cap_blk[n0+i], exp_b[i]);
                chk($sformatf("%s first%0d", tg, i), cap_first[n0+i], i == 0);
            end
        end
        chk({tg, " backpressure"}, bp_cnt - bp0, 0);
        chk({tg, " stable"}, stab_cnt - st0, 0);
    endtask

    task automatic set_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    int lens[6] = '{55, 56, 63, 67, 130, 5};
    bit got_wait;

    initial begin
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.data_last  = 1'b0;
        bus.data_bytes = '0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst in_ready", bus.in_ready, 0);
        chk("rst core_start", bus.core_start, 0);
        chk("rst core_first", bus.core_first, 0);
        chk("rst done", bus.done, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst core_block", bus.core_block, 0);

        fill(0);
        run_msg(1'b1, 1'b0);
        set_abc();
        run_msg(1'b1, 1'b0);
        chk("abc const", cap_blk[cap_blk.size()-1],
            {24'h616263, 8'h80, 416'h0, 64'h18});

        foreach (lens[i]) begin
            fill(lens[i]);
            run_msg(1'($urandom_range(0, 1)), 1'b0);
        end
        fill(64);
        run_msg(1'b1, 1'b0);
        fill(64);
        run_msg(1'b0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            fill(int'($urandom_range(0, 200)));
            run_msg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset while the core is busy on a block.
        @(negedge clk);
        bus.start      = 1'b1;
        bus.data_valid = 1'b1;
        bus.data_last  = 1'b1;
        bus.data_bytes = 3'd3;
        bus.data_in    = $urandom;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.data_valid = 1'b0;
        got_wait = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!bus.core_ready) begin
                got_wait = 1'b1;
                break;
            end
        end
        chk("mid wait reached", got_wait, 1);
        rst = 1'b1;
        #1;
        chk("mid in_ready", bus.in_ready, 0);
        chk("mid core_start", bus.core_start, 0);
        chk("mid core_first", bus.core_first, 0);
        chk("mid done", bus.done, 0);
        chk("mid busy", bus.busy, 0);
        chk("mid core_block", bus.core_block, 0);
        @(negedge clk);
        rst = 1'b0;
        set_abc();
        run_msg(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
